mag_sq_feeder: RTL and testbench
================================

Name: mag_sq_feeder

Overview:
- Upstream feeder for the 32-bit pipelined integer square-root stage.
- Accepts signed I/Q sample pairs over a valid/ready handshake and computes the squared magnitude I² + Q² with a sequential shift-add multiplier.
- Presents the result as a single-cycle valid pulse plus data, matching the sqrt stage's valid_in/data_i input.
- The sqrt stage has no backpressure, so this block throttles the input stream.

Parameters:
- IN_WIDTH, 16, width of each signed I and Q input sample.
- OUT_WIDTH, 2*IN_WIDTH, width of the squared-magnitude output. It feeds the sqrt DATA_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an I/Q pair is offered.
- in_ready  output  1  block can accept a pair this cycle.
- i_data  input  IN_WIDTH  signed I sample, two's complement.
- q_data  input  IN_WIDTH  signed Q sample, two's complement.
- valid_out  output  1  one-cycle pulse; data_o holds a valid result. Connects to the sqrt valid_in.
- data_o  output  OUT_WIDTH  unsigned I² + Q². Connects to the sqrt data_i.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - in_ready = 1 from the first cycle after reset.
  - valid_out = 0, data_o = 0, busy = 0.
  - FSM in IDLE; accumulator, multiplicand and multiplier registers cleared.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a rising edge. Call this cycle T.
  - in_ready = (state == IDLE). It is registered-state derived, with no combinational path from in_valid.
  - Upstream must hold i_data/q_data stable while in_valid is high and in_ready is low.
- Operand capture at accept:
  - Register |i_data| and |q_data| as IN_WIDTH-bit unsigned values.
  - The most negative value -2^(IN_WIDTH-1) maps to 2^(IN_WIDTH-1), which fits unsigned.
- FSM states:
  - IDLE: on accept, go to SQ_I and clear the accumulator.
  - SQ_I: IN_WIDTH cycles, one multiplier bit per cycle, LSB first. If the bit is set, add the shifted multiplicand to the OUT_WIDTH accumulator. A bit counter runs 0..IN_WIDTH-1. At the terminal count, go to SQ_Q and load the |q| operands.
  - SQ_Q: IN_WIDTH cycles, same procedure, accumulating onto the I² result. At the terminal count, go to OUT.
  - OUT: valid_out = 1 and data_o = accumulator for exactly this cycle. Then go to IDLE.
- Latency and throughput:
  - valid_out is high in cycle T + 2*IN_WIDTH + 1 (T+33 at default).
  - The next accept can occur at the earliest in cycle T + 2*IN_WIDTH + 2.
  - Throughput is one result per 2*IN_WIDTH+2 cycles.
- Arithmetic:
  - Maximum result is 2 * 2^(2*IN_WIDTH-2) = 2^(OUT_WIDTH-1). No overflow; no saturation logic.
- data_o:
  - Updated only in OUT.
  - Driven to 0 in every cycle valid_out = 0, matching the sqrt stage's zeroing style.
- Boundary conditions:
  - in_valid asserted while busy: ignored, not queued.
  - in_valid and the OUT state in the same cycle: not accepted. Acceptance happens the following IDLE cycle.
  - rst mid-computation: the next state is IDLE, the in-flight result is discarded, no valid_out pulse follows, and in_ready is high the cycle after reset deasserts.
  - Inputs of 0: the full latency still applies; data_o = 0 with valid_out = 1.

Optional Feature:
- Macro MAG_SQ_BYPASS_EN.
- When defined:
  - Adds input port bypass_i (1 bit), sampled at accept.
  - If bypass_i = 1, the FSM goes IDLE -> OUT directly.
  - valid_out is high at T+1 with data_o = {i_data, q_data} raw bits captured at accept. This lets the bench drive arbitrary 32-bit values into the sqrt stage.
  - If bypass_i = 0, behaviour is normal.
- When undefined:
  - Port bypass_i is absent, and no bypass logic or state path exists.

Test Plan:
- Reset then i=3, q=4 accepted at T -> valid_out=1 only at T+33, data_o=25 (0x19); in_ready low T+1..T+33, high at T+34.
- i=-32768, q=-32768 -> data_o=0x8000_0000 at T+33; i=-1, q=32767 -> 0x3FFF_0002.
- in_valid held high continuously with (1,1) then (2,2) -> results 2 at T+33 and 8 at T+67; the second pair is accepted at T+34; no extra or duplicate pulses.
- Accept (100,200) at T, assert rst at T+10 for one cycle -> no valid_out ever for that pair; in_ready=1, busy=0, data_o=0 from T+11.
- i=0, q=0 -> valid_out at T+33 with data_o=0.
- MAG_SQ_BYPASS_EN defined, bypass_i=1, i=0xFFFF, q=0xFFFE -> valid_out at T+1, data_o=0xFFFF_FFFE; next accept possible at T+2.

Source files
------------

// File: rtl/mag_sq_feeder_if.sv
// rtl/mag_sq_feeder_if.sv - I/Q input handshake and squared-magnitude output bundle (MAG_SQ_BYPASS_EN adds bypass_i)
interface mag_sq_feeder_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 2 * IN_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  i_data;
    logic [IN_WIDTH-1:0]  q_data;
    logic                 valid_out;
    logic [OUT_WIDTH-1:0] data_o;
    logic                 busy;
`ifdef MAG_SQ_BYPASS_EN
    logic                 bypass_i;

    modport master (
        output in_valid, i_data, q_data, bypass_i,
        input  in_ready, valid_out, data_o, busy
    );
    modport slave (
        input  in_valid, i_data, q_data, bypass_i,
        output in_ready, valid_out, data_o, busy
    );
`else
    modport master (
        output in_valid, i_data, q_data,
        input  in_ready, valid_out, data_o, busy
    );
    modport slave (
        input  in_valid, i_data, q_data,
        output in_ready, valid_out, data_o, busy
    );
`endif
endinterface

// File: rtl/mag_sq_feeder.sv
// rtl/mag_sq_feeder.sv - I^2 + Q^2 shift-add feeder for the sqrt stage (optional MAG_SQ_BYPASS_EN raw pass-through)
module mag_sq_feeder #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mag_sq_feeder_if.slave bus
);
    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SQ_I, SQ_Q, OUT} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] mcand;
    logic [IN_WIDTH-1:0]  mplier;
    logic [IN_WIDTH-1:0]  q_abs_r;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 accept;
    logic                 last_bit;
    logic                 take_bypass;
    logic [IN_WIDTH-1:0]  i_abs;
    logic [IN_WIDTH-1:0]  q_abs;

    // Two's-complement negate in IN_WIDTH bits; the most negative value lands on 2^(IN_WIDTH-1) unsigned.
    function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    assign i_abs    = abs_val(bus.i_data);
    assign q_abs    = abs_val(bus.q_data);
    assign last_bit = (bit_cnt == CNT_LAST);

`ifdef MAG_SQ_BYPASS_EN
    assign take_bypass = bus.bypass_i;
`else
    assign take_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.valid_out = (state == OUT);
        bus.data_o    = (state == OUT) ? acc : '0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = take_bypass ? OUT : SQ_I;
                end
            end
            SQ_I:    if (last_bit) state_nxt = SQ_Q;
            SQ_Q:    if (last_bit) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplicand walks left and multiplier walks right, one multiplier bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            q_abs_r <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= take_bypass ? OUT_WIDTH'({bus.i_data, bus.q_data}) : '0;
                        mcand   <= OUT_WIDTH'(i_abs);
                        mplier  <= i_abs;
                        q_abs_r <= q_abs;
                        bit_cnt <= '0;
                    end
                end
                SQ_I, SQ_Q: begin
                    if (mplier[0]) acc <= acc + mcand;
                    if (last_bit && state == SQ_I) begin
                        mcand   <= OUT_WIDTH'(q_abs_r);
                        mplier  <= q_abs_r;
                        bit_cnt <= '0;
                    end else begin
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mag_sq_feeder.sv
// tb/tb_mag_sq_feeder.sv - directed vector bench for mag_sq_feeder
module tb_mag_sq_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mag_sq_feeder_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();

    mag_sq_feeder #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [31:0] expv;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Waits (at negedges) for in_ready, bounded; returns 1 when ready.
    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int pulses;
        int pulse_cyc;
        logic [31:0] pulse_data;
        int ready_bad;
        int zero_bad;
        wait_ready(v.name, ok);
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.i_data   = v.i;
        bus.q_data   = v.q;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        pulses = 0; pulse_cyc = -1; pulse_data = '0; ready_bad = 0; zero_bad = 0;
        for (int c = 1; c <= 36; c++) begin
            if (bus.valid_out === 1'b1) begin
                pulses++;
                pulse_cyc  = c;
                pulse_data = bus.data_o;
            end else if (bus.data_o !== 32'd0) begin
                zero_bad++;
            end
            if (bus.in_ready !== ((c >= 34) ? 1'b1 : 1'b0)) ready_bad++;
            @(negedge clk);
        end
        check({v.name, "_pulses"}, 32'(pulses), 32'd1);
        check({v.name, "_latency"}, 32'(pulse_cyc), 32'd33);
        check({v.name, "_data"}, pulse_data, v.expv);
        check({v.name, "_ready_window"}, 32'(ready_bad), 32'd0);
        check({v.name, "_data_zeroed"}, 32'(zero_bad), 32'd0);
    endtask

    initial begin
        int pulses;
        int cyc[4];
        logic [31:0] dat[4];
        int bad;
        bit ok;

        vecs[0] = '{16'd3,      16'd4,      32'd25,          "i3_q4"};
        vecs[1] = '{16'h8000,   16'h8000,   32'h8000_0000,   "neg_max"};
        vecs[2] = '{16'hFFFF,   16'h7FFF,   32'h3FFF_0002,   "m1_posmax"};
        vecs[3] = '{16'd0,      16'd0,      32'd0,           "zeros"};
        vecs[4] = '{16'hFFFB,   16'd12,     32'd169,         "m5_q12"};
        vecs[5] = '{16'h7FFF,   16'h7FFF,   32'h7FFE_0002,   "pos_max"};

        bus.in_valid = 1'b0;
        bus.i_data   = '0;
        bus.q_data   = '0;
`ifdef MAG_SQ_BYPASS_EN
        bus.bypass_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_valid_out", 32'(bus.valid_out), 32'd0);
        check("reset_data_o", bus.data_o, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // in_valid held high across two pairs: second accept waits for IDLE after OUT.
        wait_ready("b2b", ok);
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.i_data   = 16'd1;
            bus.q_data   = 16'd1;
            @(posedge clk);
            @(negedge clk);
            bus.i_data = 16'd2;
            bus.q_data = 16'd2;
            pulses = 0;
            for (int c = 1; c <= 72; c++) begin
                if (c == 35) bus.in_valid = 1'b0;
                if (bus.valid_out === 1'b1) begin
                    if (pulses < 4) begin
                        cyc[pulses] = c;
                        dat[pulses] = bus.data_o;
                    end
                    pulses++;
                end
                @(negedge clk);
            end
            check("b2b_pulses", 32'(pulses), 32'd2);
            if (pulses >= 2) begin
                check("b2b_first_cyc", 32'(cyc[0]), 32'd33);
                check("b2b_first_data", dat[0], 32'd2);
                check("b2b_second_cyc", 32'(cyc[1]), 32'd67);
                check("b2b_second_data", dat[1], 32'd8);
            end
        end

        // Reset mid-computation discards the in-flight result.
        wait_ready("rst_mid", ok);
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.i_data   = 16'd100;
            bus.q_data   = 16'd200;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("rst_mid_busy_T1", 32'(bus.busy), 32'd1);
            for (int c = 1; c < 10; c++) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_mid_busy", 32'(bus.busy), 32'd0);
            check("rst_mid_data_o", bus.data_o, 32'd0);
            bad = 0;
            for (int c = 0; c < 40; c++) begin
                if (bus.valid_out !== 1'b0 || bus.in_ready !== 1'b1) bad++;
                @(negedge clk);
            end
            check("rst_mid_no_pulse", 32'(bad), 32'd0);
        end

`ifdef MAG_SQ_BYPASS_EN
        wait_ready("bypass", ok);
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.bypass_i = 1'b1;
            bus.i_data   = 16'hFFFF;
            bus.q_data   = 16'hFFFE;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.bypass_i = 1'b0;
            check("bypass_valid_T1", 32'(bus.valid_out), 32'd1);
            check("bypass_data_T1", bus.data_o, 32'hFFFF_FFFE);
            @(negedge clk);
            check("bypass_ready_T2", 32'(bus.in_ready), 32'd1);
            check("bypass_valid_T2", 32'(bus.valid_out), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
